trdb_packet_scheduler: RTL and testbench

Sits between the packet-format priority logic and the packet emitter of the trace encoder. Buffers packet requests in a small FIFO and releases them to the emitter under a valid/ready handshake. Owns the resync counter and the branch-map flush pulse, records dropped requests, and sequences the final support packets when tracing is disabled or requests are lost.

---
 rtl/trdb_packet_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_trdb_packet_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/trdb_packet_scheduler.sv
// trdb_packet_scheduler: buffers packet requests from the priority logic in a
// small FIFO and hands them to the packet emitter over valid/ready. It also
// injects the lost-packet and disable support packets, pulses the branch-map
// flush, and maintains the resync counter.
// Optional build macro TRDB_RESYNC_CYCLE_CNT_EN: when defined, the resync
// counter advances every RUN cycle; otherwise it advances once per popped
// FIFO entry.
module trdb_packet_scheduler #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RESYNC_W   = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic                req_valid_i,
  input  logic [1:0]          req_format_i,
  input  logic [1:0]          req_subformat_i,
  input  logic                req_thaddr_i,
  input  logic                req_cause_mux_i,
  input  logic                req_tval_mux_i,
  input  logic                req_resync_rst_i,
  input  logic [RESYNC_W-1:0] resync_max_i,
  output logic                pkt_valid_o,
  input  logic                pkt_ready_i,
  output logic [1:0]          pkt_format_o,
  output logic [1:0]          pkt_subformat_o,
  output logic                pkt_thaddr_o,
  output logic                pkt_cause_mux_o,
  output logic                pkt_tval_mux_o,
  output logic                pkt_lost_o,
  output logic                pkt_disable_o,
  output logic                max_resync_o,
  output logic                branch_map_flush_o,
  output logic                fifo_full_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [1:0] F_DIFF_DELTA = 2'd1;
  localparam logic [1:0] F_SYNC       = 2'd3;
  localparam logic [1:0] SF_SUPPORT   = 2'd3;

  typedef enum logic [1:0] {OFF, RUN, DRAIN, FINAL} state_e;
  // What the output register currently presents to the emitter.
  typedef enum logic [1:0] {K_NONE, K_FIFO, K_LOST, K_FINAL} kind_e;

  typedef struct packed {
    logic [1:0] fmt;
    logic [1:0] sub;
    logic       thaddr;
    logic       cause_mux;
    logic       tval_mux;
  } entry_t;

  entry_t              mem [FIFO_DEPTH];
  entry_t              req_entry, head_next;
  entry_t              out_reg, out_next;
  state_e              state_reg, state_next;
  kind_e               kind_reg, kind_next;
  logic [AW-1:0]       rd_ptr_reg, rd_ptr_next, wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]       count_reg, count_next;
  logic                lost_reg, lost_next;
  logic [RESYNC_W-1:0] resync_reg, resync_next;
  logic                pkt_lost_reg, pkt_lost_next;
  logic                pkt_disable_reg, pkt_disable_next;
  logic                full_reg, full_next;
  logic                flush_reg, flush_next;
  logic                max_reg, max_next;
  logic                handshake, fifo_pop, push, drop, resync_inc;

  // Next-state logic: FSM, FIFO bookkeeping, output selection, resync counter.
  always_comb begin
    req_entry  = {req_format_i, req_subformat_i, req_thaddr_i, req_cause_mux_i, req_tval_mux_i};
    handshake  = (kind_reg != K_NONE) && pkt_ready_i;
    fifo_pop   = handshake && (kind_reg == K_FIFO);
    push       = (state_reg == RUN) && req_valid_i && ((count_reg != COUNT_FULL) || fifo_pop);
    drop       = (state_reg == RUN) && req_valid_i && !push;

    state_next = state_reg;
    case (state_reg)
      OFF:     if (enable_i) state_next = RUN;
      RUN:     if (!enable_i) state_next = DRAIN;
      DRAIN:   if (count_reg == '0) state_next = FINAL;
      FINAL:   if (handshake && (kind_reg == K_FINAL)) state_next = OFF;
      default: state_next = OFF;
    endcase

    // A drop in the same cycle as a lost report must stay visible, so set wins.
    lost_next = lost_reg;
    if (handshake && ((kind_reg == K_LOST) || (kind_reg == K_FINAL))) lost_next = 1'b0;
    if (drop) lost_next = 1'b1;

    wr_ptr_next = wr_ptr_reg + AW'(push);
    rd_ptr_next = rd_ptr_reg + AW'(fifo_pop);
    count_next  = count_reg + CW'(push) - CW'(fifo_pop);

    // When the entry being written becomes the only one, bypass the array.
    head_next = (push && (count_next == CW'(1))) ? req_entry : mem[rd_ptr_next];

    // Presented packet is held until it handshakes; otherwise pick the next one.
    kind_next        = kind_reg;
    out_next         = out_reg;
    pkt_lost_next    = pkt_lost_reg;
    pkt_disable_next = pkt_disable_reg;
    if ((kind_reg == K_NONE) || handshake) begin
      kind_next        = K_NONE;
      out_next         = '0;
      pkt_lost_next    = 1'b0;
      pkt_disable_next = 1'b0;
      if (state_next == FINAL) begin
        kind_next        = K_FINAL;
        out_next         = {F_SYNC, SF_SUPPORT, 3'b000};
        pkt_lost_next    = lost_next;
        pkt_disable_next = 1'b1;
      end else if ((state_next == RUN) && lost_next && (count_next == '0)) begin
        kind_next     = K_LOST;
        out_next      = {F_SYNC, SF_SUPPORT, 3'b000};
        pkt_lost_next = 1'b1;
      end else if (count_next != '0) begin
        kind_next = K_FIFO;
        out_next  = head_next;
      end
    end

`ifdef TRDB_RESYNC_CYCLE_CNT_EN
    resync_inc = (state_reg == RUN);
`else
    resync_inc = (state_reg == RUN) && fifo_pop;
`endif
    resync_next = resync_reg;
    if (resync_inc && (resync_reg != '1)) resync_next = resync_reg + RESYNC_W'(1);
    if (push && req_resync_rst_i) resync_next = '0;
    if ((state_reg == RUN) && (state_next != RUN)) resync_next = '0;

    max_next   = (resync_max_i != '0) && (resync_next >= resync_max_i);
    full_next  = (count_next == COUNT_FULL);
    flush_next = push && ((req_format_i == F_DIFF_DELTA) || (req_format_i == F_SYNC));
  end

  // Control and output registers; reset returns everything to idle at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg       <= OFF;
      kind_reg        <= K_NONE;
      out_reg         <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
      lost_reg        <= 1'b0;
      resync_reg      <= '0;
      pkt_lost_reg    <= 1'b0;
      pkt_disable_reg <= 1'b0;
      full_reg        <= 1'b0;
      flush_reg       <= 1'b0;
      max_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      kind_reg        <= kind_next;
      out_reg         <= out_next;
      rd_ptr_reg      <= rd_ptr_next;
      wr_ptr_reg      <= wr_ptr_next;
      count_reg       <= count_next;
      lost_reg        <= lost_next;
      resync_reg      <= resync_next;
      pkt_lost_reg    <= pkt_lost_next;
      pkt_disable_reg <= pkt_disable_next;
      full_reg        <= full_next;
      flush_reg       <= flush_next;
      max_reg         <= max_next;
    end
  end

  // FIFO storage; contents need no reset since the pointers qualify them.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_reg] <= req_entry;
  end

  assign pkt_valid_o        = (kind_reg != K_NONE);
  assign pkt_format_o       = out_reg.fmt;
  assign pkt_subformat_o    = out_reg.sub;
  assign pkt_thaddr_o       = out_reg.thaddr;
  assign pkt_cause_mux_o    = out_reg.cause_mux;
  assign pkt_tval_mux_o     = out_reg.tval_mux;
  assign pkt_lost_o         = pkt_lost_reg;
  assign pkt_disable_o      = pkt_disable_reg;
  assign max_resync_o       = max_reg;
  assign branch_map_flush_o = flush_reg;
  assign fifo_full_o        = full_reg;

endmodule

// File: tb/tb_trdb_packet_scheduler.sv
// Directed self-checking bench for trdb_packet_scheduler (default build).
module tb_trdb_packet_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        enable_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic [1:0]  req_format_i = '0;
  logic [1:0]  req_subformat_i = '0;
  logic        req_thaddr_i = 1'b0;
  logic        req_cause_mux_i = 1'b0;
  logic        req_tval_mux_i = 1'b0;
  logic        req_resync_rst_i = 1'b0;
  logic [15:0] resync_max_i = '0;
  logic        pkt_ready_i = 1'b0;
  logic        pkt_valid_o;
  logic [1:0]  pkt_format_o;
  logic [1:0]  pkt_subformat_o;
  logic        pkt_thaddr_o, pkt_cause_mux_o, pkt_tval_mux_o;
  logic        pkt_lost_o, pkt_disable_o, max_resync_o, branch_map_flush_o, fifo_full_o;
  logic [6:0]  head;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] SUPPORT = 7'b11_11_000;

  trdb_packet_scheduler #(.FIFO_DEPTH(4), .RESYNC_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i),
    .req_valid_i(req_valid_i), .req_format_i(req_format_i), .req_subformat_i(req_subformat_i),
    .req_thaddr_i(req_thaddr_i), .req_cause_mux_i(req_cause_mux_i), .req_tval_mux_i(req_tval_mux_i),
    .req_resync_rst_i(req_resync_rst_i), .resync_max_i(resync_max_i),
    .pkt_valid_o(pkt_valid_o), .pkt_ready_i(pkt_ready_i),
    .pkt_format_o(pkt_format_o), .pkt_subformat_o(pkt_subformat_o),
    .pkt_thaddr_o(pkt_thaddr_o), .pkt_cause_mux_o(pkt_cause_mux_o), .pkt_tval_mux_o(pkt_tval_mux_o),
    .pkt_lost_o(pkt_lost_o), .pkt_disable_o(pkt_disable_o), .max_resync_o(max_resync_o),
    .branch_map_flush_o(branch_map_flush_o), .fifo_full_o(fifo_full_o)
  );

  assign head = {pkt_format_o, pkt_subformat_o, pkt_thaddr_o, pkt_cause_mux_o, pkt_tval_mux_o};

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic [6:0] e, input logic rr);
    req_valid_i      = v;
    {req_format_i, req_subformat_i, req_thaddr_i, req_cause_mux_i, req_tval_mux_i} = e;
    req_resync_rst_i = rr;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    enable_i = 1'b0;
    pkt_ready_i = 1'b0;
    resync_max_i = '0;
    drive_req(1'b0, 7'b0, 1'b0);
    step();
    step();
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    step();
    checks++; if (pkt_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", pkt_valid_o); end
    checks++; if (head !== 7'b0) begin errors++; $display("FAIL reset_payload: got %b want 0000000", head); end
    checks++; if ({pkt_lost_o, pkt_disable_o} !== 2'b00) begin errors++; $display("FAIL reset_lost_dis: got %b want 00", {pkt_lost_o, pkt_disable_o}); end
    checks++; if ({max_resync_o, branch_map_flush_o, fifo_full_o} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {max_resync_o, branch_map_flush_o, fifo_full_o}); end
    rst_ni = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    do_reset();
    pkt_ready_i = 1'b1;
    enable_i = 1'b1;
    step();
    checks++; if (pkt_valid_o !== 1'b0) begin errors++; $display("FAIL basic_idle_valid: got %b want 0", pkt_valid_o); end
    drive_req(1'b1, 7'b10_00_100, 1'b0);
    step();
    checks++; if (pkt_valid_o !== 1'b1 || head !== 7'b10_00_100) begin errors++; $display("FAIL basic_pkt1: valid=%b head=%b want 1 1000100", pkt_valid_o, head); end
    checks++; if (branch_map_flush_o !== 1'b0) begin errors++; $display("FAIL basic_flush1: got %b want 0", branch_map_flush_o); end
    drive_req(1'b1, 7'b11_01_011, 1'b0);
    step();
    checks++; if (pkt_valid_o !== 1'b1 || head !== 7'b11_01_011) begin errors++; $display("FAIL basic_pkt2: valid=%b head=%b want 1 1101011", pkt_valid_o, head); end
    checks++; if (branch_map_flush_o !== 1'b1) begin errors++; $display("FAIL basic_flush2: got %b want 1", branch_map_flush_o); end
    drive_req(1'b0, 7'b0, 1'b0);
    step();
    checks++; if (pkt_valid_o !== 1'b0 || branch_map_flush_o !== 1'b0) begin errors++; $display("FAIL basic_end: valid=%b flush=%b want 0 0", pkt_valid_o, branch_map_flush_o); end
    $display("test_basic done");
  endtask

  task automatic test_overflow();
    logic [6:0] ov [0:5];
    ov = '{7'b10_00_100, 7'b01_00_010, 7'b00_00_001, 7'b10_00_111, 7'b01_00_101, 7'b01_00_101};
    do_reset();
    enable_i = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      drive_req(1'b1, ov[i], 1'b0);
      step();
    end
    drive_req(1'b0, 7'b0, 1'b0);
    checks++; if (fifo_full_o !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", fifo_full_o); end
    pkt_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (pkt_valid_o !== 1'b1 || head !== ov[i] || pkt_lost_o !== 1'b0) begin errors++; $display("FAIL ovf_pkt%0d: valid=%b head=%b lost=%b want 1 %b 0", i, pkt_valid_o, head, pkt_lost_o, ov[i]); end
      step();
    end
    checks++; if (pkt_valid_o !== 1'b1 || head !== SUPPORT || pkt_lost_o !== 1'b1 || pkt_disable_o !== 1'b0) begin errors++; $display("FAIL ovf_lost_pkt: valid=%b head=%b lost=%b dis=%b want 1 %b 1 0", pkt_valid_o, head, pkt_lost_o, pkt_disable_o, SUPPORT); end
    checks++; if (fifo_full_o !== 1'b0) begin errors++; $display("FAIL ovf_not_full: got %b want 0", fifo_full_o); end
    step();
    checks++; if (pkt_valid_o !== 1'b0 || pkt_lost_o !== 1'b0) begin errors++; $display("FAIL ovf_after_lost: valid=%b lost=%b want 0 0", pkt_valid_o, pkt_lost_o); end
    $display("test_overflow done");
  endtask

  task automatic test_full_push_pop();
    logic [6:0] fe [0:4];
    fe = '{7'b00_00_001, 7'b00_00_010, 7'b00_00_100, 7'b10_00_011, 7'b10_00_110};
    do_reset();
    enable_i = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b1, fe[i], 1'b0);
      step();
    end
    checks++; if (fifo_full_o !== 1'b1) begin errors++; $display("FAIL fpp_full_before: got %b want 1", fifo_full_o); end
    drive_req(1'b1, fe[4], 1'b0);
    pkt_ready_i = 1'b1;
    step();
    drive_req(1'b0, 7'b0, 1'b0);
    pkt_ready_i = 1'b0;
    checks++; if (fifo_full_o !== 1'b1 || head !== fe[1]) begin errors++; $display("FAIL fpp_full_after: full=%b head=%b want 1 %b", fifo_full_o, head, fe[1]); end
    pkt_ready_i = 1'b1;
    for (int i = 1; i < 5; i++) begin
      checks++; if (pkt_valid_o !== 1'b1 || head !== fe[i]) begin errors++; $display("FAIL fpp_pkt%0d: valid=%b head=%b want 1 %b", i, pkt_valid_o, head, fe[i]); end
      step();
    end
    checks++; if (pkt_valid_o !== 1'b0 || fifo_full_o !== 1'b0) begin errors++; $display("FAIL fpp_no_drop: valid=%b full=%b want 0 0", pkt_valid_o, fifo_full_o); end
    $display("test_full_push_pop done");
  endtask

  task automatic test_resync();
    do_reset();
    enable_i = 1'b1;
    resync_max_i = 16'd3;
    pkt_ready_i = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b1, 7'b10_00_000, 1'b0);
      step();
    end
    checks++; if (max_resync_o !== 1'b0) begin errors++; $display("FAIL resync_two_pops: got %b want 0", max_resync_o); end
    drive_req(1'b0, 7'b0, 1'b0);
    step();
    checks++; if (max_resync_o !== 1'b1) begin errors++; $display("FAIL resync_three_pops: got %b want 1", max_resync_o); end
    drive_req(1'b1, 7'b11_00_000, 1'b1);
    step();
    checks++; if (max_resync_o !== 1'b0 || branch_map_flush_o !== 1'b1 || head !== 7'b11_00_000) begin errors++; $display("FAIL resync_clear: max=%b flush=%b head=%b want 0 1 1100000", max_resync_o, branch_map_flush_o, head); end
    drive_req(1'b0, 7'b0, 1'b0);
    step();
    checks++; if (max_resync_o !== 1'b0) begin errors++; $display("FAIL resync_after_clear: got %b want 0", max_resync_o); end
    $display("test_resync done");
  endtask

  task automatic test_disable();
    do_reset();
    enable_i = 1'b1;
    step();
    drive_req(1'b1, 7'b10_00_101, 1'b0);
    step();
    drive_req(1'b1, 7'b01_00_011, 1'b0);
    step();
    drive_req(1'b0, 7'b0, 1'b0);
    enable_i = 1'b0;
    pkt_ready_i = 1'b1;
    checks++; if (pkt_valid_o !== 1'b1 || head !== 7'b10_00_101) begin errors++; $display("FAIL dis_pkt0: valid=%b head=%b want 1 1000101", pkt_valid_o, head); end
    step();
    checks++; if (pkt_valid_o !== 1'b1 || head !== 7'b01_00_011) begin errors++; $display("FAIL dis_pkt1: valid=%b head=%b want 1 0100011", pkt_valid_o, head); end
    step();
    checks++; if (pkt_valid_o !== 1'b0) begin errors++; $display("FAIL dis_gap: got %b want 0", pkt_valid_o); end
    step();
    checks++; if (pkt_valid_o !== 1'b1 || head !== SUPPORT || pkt_disable_o !== 1'b1 || pkt_lost_o !== 1'b0) begin errors++; $display("FAIL dis_final: valid=%b head=%b dis=%b lost=%b want 1 %b 1 0", pkt_valid_o, head, pkt_disable_o, pkt_lost_o, SUPPORT); end
    step();
    checks++; if (pkt_valid_o !== 1'b0 || pkt_disable_o !== 1'b0) begin errors++; $display("FAIL dis_off: valid=%b dis=%b want 0 0", pkt_valid_o, pkt_disable_o); end
    drive_req(1'b1, 7'b11_01_000, 1'b0);
    step();
    drive_req(1'b0, 7'b0, 1'b0);
    checks++; if (pkt_valid_o !== 1'b0 || branch_map_flush_o !== 1'b0) begin errors++; $display("FAIL dis_ignored: valid=%b flush=%b want 0 0", pkt_valid_o, branch_map_flush_o); end
    step();
    checks++; if (pkt_valid_o !== 1'b0) begin errors++; $display("FAIL dis_ignored_late: got %b want 0", pkt_valid_o); end
    $display("test_disable done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable_i = 1'b1;
    resync_max_i = 16'd1;
    step();
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b1, 7'b10_00_001, 1'b0);
      step();
    end
    pkt_ready_i = 1'b1;
    step();
    pkt_ready_i = 1'b0;
    checks++; if (pkt_valid_o !== 1'b1 || max_resync_o !== 1'b1) begin errors++; $display("FAIL rmid_before: valid=%b max=%b want 1 1", pkt_valid_o, max_resync_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if (pkt_valid_o !== 1'b0 || head !== 7'b0 || max_resync_o !== 1'b0 || fifo_full_o !== 1'b0) begin errors++; $display("FAIL rmid_async: valid=%b head=%b max=%b full=%b want 0 0000000 0 0", pkt_valid_o, head, max_resync_o, fifo_full_o); end
    step();
    step();
    rst_ni = 1'b1;
    drive_req(1'b0, 7'b0, 1'b0);
    step();
    step();
    checks++; if (pkt_valid_o !== 1'b0 || max_resync_o !== 1'b0) begin errors++; $display("FAIL rmid_after: valid=%b max=%b want 0 0", pkt_valid_o, max_resync_o); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_resync();
    test_disable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
